// File: rtl/tone_div_pkg.sv
// Shared constants, FSM state type and high-phase helper for the tone divider voices.
package tone_div_pkg;

  localparam int unsigned DIV_W_DEF = 24;
  localparam int unsigned MIN_DIV   = 2;
  localparam int unsigned DIV_MUTE  = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tone_state_e;

  // ceil(div/2) without forming div+1, so the all-ones divide value cannot wrap
  function automatic logic [63:0] high_len(input logic [63:0] div);
    return (div >> 1) + {63'd0, div[0]};
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Runtime-programmable square-wave divider for one keyboard voice; pitch changes land on period boundaries.
// Optional O_TICK period strobe is built when TONE_DIVIDER_TICK_EN is defined.
module tone_divider
  import tone_div_pkg::*;
#(
  parameter int unsigned           DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0]      RST_DIV = DIV_W'(DIV_MUTE)
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_EN,
  input  logic             I_LOAD,
  input  logic [DIV_W-1:0] I_DIV,
  output logic             O_CLK,
  output logic             O_PEND
`ifdef TONE_DIVIDER_TICK_EN
  ,
  output logic             O_TICK
`endif
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_q, clk_d;
  logic [DIV_W-1:0] h_s;
  logic [DIV_W-1:0] last_s;
  tone_state_e      state_s;
`ifdef TONE_DIVIDER_TICK_EN
  logic             tick_q, tick_d;
`endif

  // The state is a pure decode of the active divide value and the enable
  always_comb begin
    state_s = IDLE;
    if (I_EN && (div_act_q >= DIV_W'(MIN_DIV))) begin
      state_s = RUN;
    end else begin
      state_s = IDLE;
    end
  end

  // Period arithmetic on the active divide value
  always_comb begin
    h_s    = DIV_W'(high_len(64'(div_act_q)));
    last_s = div_act_q - DIV_W'(1);
  end

  // Next-state logic: counting, load staging and boundary hand-over
  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_v_d   = pend_v_q;
    clk_d      = 1'b0;
`ifdef TONE_DIVIDER_TICK_EN
    tick_d     = 1'b0;
`endif
    case (state_s)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (I_LOAD) begin
          div_act_d = I_DIV;
          pend_v_d  = 1'b0;
        end else if (pend_v_q) begin
          div_act_d = div_pend_q;
          pend_v_d  = 1'b0;
        end else begin
          div_act_d = div_act_q;
        end
      end
      RUN: begin
        clk_d = (cnt_q < h_s);
`ifdef TONE_DIVIDER_TICK_EN
        tick_d = (cnt_q == '0);
`endif
        if (cnt_q == last_s) begin
          // A strobe on the boundary cycle bypasses the pending register
          cnt_d    = '0;
          pend_v_d = 1'b0;
          if (I_LOAD) begin
            div_act_d = I_DIV;
          end else if (pend_v_q) begin
            div_act_d = div_pend_q;
          end else begin
            div_act_d = div_act_q;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
          if (I_LOAD) begin
            div_pend_d = I_DIV;
            pend_v_d   = 1'b1;
          end else begin
            div_pend_d = div_pend_q;
          end
        end
      end
      default: begin
        cnt_d = '0;
        clk_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      cnt_q      <= '0;
      div_act_q  <= RST_DIV;
      div_pend_q <= '0;
      pend_v_q   <= 1'b0;
      clk_q      <= 1'b0;
`ifdef TONE_DIVIDER_TICK_EN
      tick_q     <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_v_q   <= pend_v_d;
      clk_q      <= clk_d;
`ifdef TONE_DIVIDER_TICK_EN
      tick_q     <= tick_d;
`endif
    end
  end

  assign O_CLK  = clk_q;
  assign O_PEND = pend_v_q;
`ifdef TONE_DIVIDER_TICK_EN
  assign O_TICK = tick_q;
`endif

endmodule

// File: tb/tb_tone_divider.sv
// Self-checking bench for tone_divider: directed period/duty measurements plus a randomized run
// against a position-in-period reference model.
module tb_tone_divider;

  localparam int DW = 24;

  logic          I_CLK;
  logic          I_RST;
  logic          I_EN;
  logic          I_LOAD;
  logic [DW-1:0] I_DIV;
  logic          O_CLK;
  logic          O_PEND;
`ifdef TONE_DIVIDER_TICK_EN
  logic          O_TICK;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model: where we are in the period, active/pending periods
  longint m_act, m_pend, m_pos;
  bit     m_pv, m_clk, m_tick;

  tone_divider #(.DIV_W(DW), .RST_DIV('0)) dut (
    .I_CLK (I_CLK),
    .I_RST (I_RST),
    .I_EN  (I_EN),
    .I_LOAD(I_LOAD),
    .I_DIV (I_DIV),
    .O_CLK (O_CLK),
    .O_PEND(O_PEND)
`ifdef TONE_DIVIDER_TICK_EN
    ,
    .O_TICK(O_TICK)
`endif
  );

  initial begin
    I_CLK = 1'b0;
    forever #5 I_CLK = ~I_CLK;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one clock: predict from the current inputs, then compare after the edge
  task automatic tick();
    longint h_next;
    if (I_RST) begin
      m_act = 0; m_pend = 0; m_pv = 0; m_pos = 0; m_clk = 0; m_tick = 0;
    end else if (!(I_EN && m_act >= 2)) begin
      m_pos = 0; m_clk = 0; m_tick = 0;
      if (I_LOAD) begin
        m_act = longint'(I_DIV); m_pv = 0;
      end else if (m_pv) begin
        m_act = m_pend; m_pv = 0;
      end
    end else begin
      m_clk  = (2 * m_pos < m_act);
      m_tick = (m_pos == 0);
      h_next = m_pos + 1;
      if (h_next == m_act) begin
        m_pos = 0;
        if (I_LOAD) m_act = longint'(I_DIV);
        else if (m_pv) m_act = m_pend;
        m_pv = 0;
      end else begin
        m_pos = h_next;
        if (I_LOAD) begin
          m_pend = longint'(I_DIV); m_pv = 1;
        end
      end
    end
    @(posedge I_CLK);
    #1;
    check("o_clk", longint'(O_CLK), longint'(m_clk));
    check("o_pend", longint'(O_PEND), longint'(m_pv));
`ifdef TONE_DIVIDER_TICK_EN
    check("o_tick", longint'(O_TICK), longint'(m_tick));
`endif
  endtask

  task automatic load(input int d);
    I_DIV  = DW'(d);
    I_LOAD = 1'b1;
    tick();
    I_LOAD = 1'b0;
  endtask

  task automatic measure(input int n, output int highs, output int rises,
                         output int pends, output int ticks);
    bit prev;
    highs = 0; rises = 0; pends = 0; ticks = 0;
    prev = O_CLK;
    for (int i = 0; i < n; i++) begin
      tick();
      if (O_CLK) highs++;
      if (O_CLK && !prev) rises++;
      if (O_PEND) pends++;
`ifdef TONE_DIVIDER_TICK_EN
      if (O_TICK) ticks++;
`endif
      prev = O_CLK;
    end
  endtask

  task automatic wait_pos(input longint p);
    int k;
    k = 0;
    while (m_pos != p && k < 64) begin
      tick();
      k++;
    end
    check("wait_pos", m_pos, p);
  endtask

  int hi, ri, pe, tk;
  int pc;

  initial begin
    I_RST = 1'b1; I_EN = 1'b1; I_LOAD = 1'b0; I_DIV = '0;
    m_act = 0; m_pend = 0; m_pv = 0; m_pos = 0; m_clk = 0; m_tick = 0;
    tick();
    tick();
    check("rst_clk", longint'(O_CLK), 0);
    check("rst_pend", longint'(O_PEND), 0);
    I_RST = 1'b0;
    tick();

    // D=10 from idle: 5 periods of 5 high / 5 low, never pending
    load(10);
    check("d10_first", longint'(O_CLK), 0);
    measure(50, hi, ri, pe, tk);
    check("d10_high", hi, 25);
    check("d10_rise", ri, 5);
    check("d10_pend", pe, 0);
`ifdef TONE_DIVIDER_TICK_EN
    check("d10_tick", tk, 5);
`endif

    // mute via load: current period completes, then silence
    load(0);
    measure(10, hi, ri, pe, tk);
    measure(50, hi, ri, pe, tk);
    check("mute_high", hi, 0);

    // D=7 from idle: 4 high / 3 low
    load(7);
    measure(49, hi, ri, pe, tk);
    check("d7_high", hi, 28);
    check("d7_rise", ri, 7);

    // D=10 running, load 4 at cnt=3: pending for 6 cycles, then 2/2
    load(10);
    measure(20, hi, ri, pe, tk);
    wait_pos(3);
    load(4);
    pc = O_PEND;
    measure(9, hi, ri, pe, tk);
    check("d4_pendlen", pc + pe, 6);
    measure(20, hi, ri, pe, tk);
    check("d4_high", hi, 10);
    check("d4_rise", ri, 5);

    // last load before the boundary wins
    load(10);
    measure(20, hi, ri, pe, tk);
    wait_pos(2);
    load(6);
    tick();
    load(8);
    wait_pos(0);
    measure(24, hi, ri, pe, tk);
    check("lw_high", hi, 12);
    check("lw_rise", ri, 3);

    // load exactly on the boundary cycle: applies immediately, no pending
    load(10);
    measure(20, hi, ri, pe, tk);
    wait_pos(9);
    load(5);
    check("bnd_pend", longint'(O_PEND), 0);
    measure(20, hi, ri, pe, tk);
    check("bnd_high", hi, 12);
    check("bnd_rise", ri, 4);
    check("bnd_pends", pe, 0);

    // reset mid-period
    load(10);
    measure(20, hi, ri, pe, tk);
    wait_pos(6);
    I_RST = 1'b1;
    tick();
    I_RST = 1'b0;
    check("mrst_clk", longint'(O_CLK), 0);
    check("mrst_pend", longint'(O_PEND), 0);
    measure(30, hi, ri, pe, tk);
    check("mrst_high", hi, 0);

    // enable drop mid-period, then fresh full period
    load(10);
    measure(10, hi, ri, pe, tk);
    wait_pos(4);
    I_EN = 1'b0;
    tick();
    check("en_off_clk", longint'(O_CLK), 0);
    measure(5, hi, ri, pe, tk);
    check("en_off_high", hi, 0);
    I_EN = 1'b1;
    measure(10, hi, ri, pe, tk);
    check("en_on_high", hi, 5);
    check("en_on_rise", ri, 1);

    // maximum divide value, then a pending value applied through disable
    I_EN = 1'b0;
    tick();
    load((1 << DW) - 1);
    I_EN = 1'b1;
    measure(20, hi, ri, pe, tk);
    check("max_high", hi, 20);
    load(4);
    check("max_pend", longint'(O_PEND), 1);
    I_EN = 1'b0;
    tick();
    I_EN = 1'b1;
    measure(20, hi, ri, pe, tk);
    check("max_exit_high", hi, 10);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      I_RST  = ($urandom_range(0, 299) == 0);
      I_EN   = ($urandom_range(0, 19) != 0);
      I_LOAD = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0:       I_DIV = DW'($urandom_range(0, 1));
        1:       I_DIV = DW'(2);
        2:       I_DIV = DW'(3);
        default: I_DIV = DW'($urandom_range(4, 20));
      endcase
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
